// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and constants for the multi-channel level-to-pulse converter.
// Optional overrun flags are built when MULTI_PULSE_GEN_OVERRUN_EN is defined.
package multi_pulse_gen_pkg;

    localparam int SYNC_STAGES_MIN = 1;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_e;

    function automatic logic edge_hit(
        input logic [1:0] mode,
        input logic       cur,
        input logic       prev
    );
        logic hit;
        hit = 1'b0;
        unique case (1'b1)
            (mode == EDGE_RISE): hit = cur & ~prev;
            (mode == EDGE_FALL): hit = ~cur & prev;
            (mode == EDGE_BOTH): hit = cur ^ prev;
            (mode == EDGE_OFF):  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/multi_pulse_gen_if.sv
// Level-in / pulse-out bundle for multi_pulse_gen.
// OVERRUN/OVR_CLR exist only when MULTI_PULSE_GEN_OVERRUN_EN is defined.
interface multi_pulse_gen_if #(
    parameter int CH_NUM      = 4,
    parameter int PULSE_LEN_W = 4
);
    logic [CH_NUM-1:0]      LVL_SIG;
    logic [1:0]             EDGE_MODE;
    logic [PULSE_LEN_W-1:0] PULSE_LEN;
    logic [CH_NUM-1:0]      PULSE_SIG;
    logic [CH_NUM-1:0]      BUSY;
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
    logic [CH_NUM-1:0]      OVERRUN;
    logic [CH_NUM-1:0]      OVR_CLR;

    modport master (
        output LVL_SIG, EDGE_MODE, PULSE_LEN, OVR_CLR,
        input  PULSE_SIG, BUSY, OVERRUN
    );
    modport slave (
        input  LVL_SIG, EDGE_MODE, PULSE_LEN, OVR_CLR,
        output PULSE_SIG, BUSY, OVERRUN
    );
`else
    modport master (
        output LVL_SIG, EDGE_MODE, PULSE_LEN,
        input  PULSE_SIG, BUSY
    );
    modport slave (
        input  LVL_SIG, EDGE_MODE, PULSE_LEN,
        output PULSE_SIG, BUSY
    );
`endif
endinterface

// File: rtl/multi_pulse_gen_ch.sv
// One channel: synchroniser, edge history, edge detect, pulse FSM and counter.
// Sticky overrun flag is built when MULTI_PULSE_GEN_OVERRUN_EN is defined.
module pulse_gen_ch
    import multi_pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN_W = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   lvl,
    input  logic [1:0]             edge_mode,
    input  logic [PULSE_LEN_W-1:0] pulse_len,
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
    input  logic                   ovr_clr,
    output logic                   overrun,
`endif
    output logic                   pulse,
    output logic                   busy
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    ch_state_e              state;
    logic [PULSE_LEN_W-1:0] cnt;
    logic                   pulse_q;
    logic                   hit;
    logic [PULSE_LEN_W-1:0] load_val;

    assign hit      = edge_hit(edge_mode, sync[SYNC_STAGES-1], hist);
    // A length of zero still yields a one-cycle strobe.
    assign load_val = (pulse_len == '0) ? '0
                    : pulse_len - PULSE_LEN_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync    <= '0;
            hist    <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync[0] <= lvl;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            hist <= sync[SYNC_STAGES-1];
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        state   <= ACTIVE;
                        cnt     <= load_val;
                        pulse_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        pulse_q <= 1'b0;
                    end else begin
                        cnt <= cnt - PULSE_LEN_W'(1);
                    end
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign busy  = pulse_q;

`ifdef MULTI_PULSE_GEN_OVERRUN_EN
    logic ovr_q;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_q <= 1'b0;
        end else if (hit && (state == ACTIVE)) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign overrun = ovr_q;
`endif

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel level-to-pulse converter; CH_NUM independent pulse_gen_ch copies.
// Build with MULTI_PULSE_GEN_OVERRUN_EN for per-channel sticky overrun flags.
module multi_pulse_gen
    import multi_pulse_gen_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN_W = 4
) (
    input logic              CLK,
    input logic              RST,
    multi_pulse_gen_if.slave bus
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end

    logic [CH_NUM-1:0] pulse_w;
    logic [CH_NUM-1:0] busy_w;
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
    logic [CH_NUM-1:0] ovr_w;
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pulse_gen_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN_W (PULSE_LEN_W)
        ) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .lvl       (bus.LVL_SIG[g]),
            .edge_mode (bus.EDGE_MODE),
            .pulse_len (bus.PULSE_LEN),
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
            .ovr_clr   (bus.OVR_CLR[g]),
            .overrun   (ovr_w[g]),
`endif
            .pulse     (pulse_w[g]),
            .busy      (busy_w[g])
        );
    end

    assign bus.PULSE_SIG = pulse_w;
    assign bus.BUSY      = busy_w;
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
    assign bus.OVERRUN   = ovr_w;
`endif

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed-vector bench for multi_pulse_gen (4 channels, 2 sync stages).
// Overrun checks are included when MULTI_PULSE_GEN_OVERRUN_EN is defined.
module tb_multi_pulse_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    multi_pulse_gen_if #(.CH_NUM(4), .PULSE_LEN_W(4)) bus ();

    multi_pulse_gen #(
        .CH_NUM      (4),
        .SYNC_STAGES (2),
        .PULSE_LEN_W (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Steps `total` edges after the current stimulus; edge k=0 is the capture
    // edge. Pulse expected on `mask` after edges first..first+len-1.
    task automatic expect_pulse(input string tag, input logic [3:0] mask,
                                input int first, input int len,
                                input int total, input int act_at,
                                input logic [3:0] act_lvl,
                                input logic [3:0] act_len);
        for (int k = 0; k < total; k++) begin
            logic [3:0] exp;
            tick();
            exp = (k >= first && k < first + len) ? mask : 4'b0000;
            chk($sformatf("%s_p%0d", tag, k), 32'(bus.PULSE_SIG), 32'(exp));
            chk($sformatf("%s_b%0d", tag, k), 32'(bus.BUSY), 32'(exp));
            if (k == act_at) begin
                bus.LVL_SIG   = act_lvl;
                bus.PULSE_LEN = act_len;
            end
        end
    endtask

    initial begin
        bus.LVL_SIG   = 4'b0000;
        bus.EDGE_MODE = 2'b00;
        bus.PULSE_LEN = 4'd3;
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
        bus.OVR_CLR   = 4'b0000;
`endif
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_pulse", 32'(bus.PULSE_SIG), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        RST = 1'b0;
        repeat (3) tick();

        // Rise, length 3, channel 0 only
        bus.LVL_SIG = 4'b0001;
        expect_pulse("rise", 4'b0001, 2, 3, 8, -1, 4'b0, 4'd0);

        // Fall mode: 1->0 fires, 0->1 does not
        bus.EDGE_MODE = 2'b01;
        bus.PULSE_LEN = 4'd2;
        bus.LVL_SIG   = 4'b0000;
        expect_pulse("fall", 4'b0001, 2, 2, 6, -1, 4'b0, 4'd0);
        bus.LVL_SIG   = 4'b0001;
        expect_pulse("fall_up", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);

        // Both mode on channel 1: 0->1->0, ten cycles apart
        bus.EDGE_MODE = 2'b10;
        bus.LVL_SIG   = 4'b0011;
        expect_pulse("both_up", 4'b0010, 2, 2, 10, -1, 4'b0, 4'd0);
        bus.LVL_SIG   = 4'b0001;
        expect_pulse("both_dn", 4'b0010, 2, 2, 10, -1, 4'b0, 4'd0);

        // Off: nothing fires, and re-enabling reports no stale edge
        bus.EDGE_MODE = 2'b11;
        bus.LVL_SIG   = 4'b0011;
        expect_pulse("off_a", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);
        bus.LVL_SIG   = 4'b0101;
        expect_pulse("off_b", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);
        bus.EDGE_MODE = 2'b00;
        expect_pulse("reen", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);

        // Length 0 behaves as 1
        bus.PULSE_LEN = 4'd0;
        bus.LVL_SIG   = 4'b1101;
        expect_pulse("len0", 4'b1000, 2, 1, 6, -1, 4'b0, 4'd0);

        // Maximum length 15
        bus.LVL_SIG   = 4'b0101;
        expect_pulse("len15_pre", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);
        bus.PULSE_LEN = 4'd15;
        bus.LVL_SIG   = 4'b1101;
        expect_pulse("len15", 4'b1000, 2, 15, 20, -1, 4'b0, 4'd0);

        // Length change mid-pulse is ignored
        bus.LVL_SIG   = 4'b0101;
        expect_pulse("chg_pre", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);
        bus.PULSE_LEN = 4'd4;
        bus.LVL_SIG   = 4'b1101;
        expect_pulse("chg", 4'b1000, 2, 4, 10, 3, 4'b1101, 4'd9);

        // Retrigger while ACTIVE is dropped
        bus.LVL_SIG   = 4'b1100;
        expect_pulse("rtg_pre", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
        chk("ovr_before", 32'(bus.OVERRUN), 32'h0);
`endif
        bus.EDGE_MODE = 2'b10;
        bus.PULSE_LEN = 4'd5;
        bus.LVL_SIG   = 4'b1101;
        expect_pulse("rtg", 4'b0001, 2, 5, 14, 2, 4'b1100, 4'd5);
`ifdef MULTI_PULSE_GEN_OVERRUN_EN
        chk("ovr_set", 32'(bus.OVERRUN), 32'h1);
        tick();
        chk("ovr_hold", 32'(bus.OVERRUN), 32'h1);
        bus.OVR_CLR = 4'b0001;
        tick();
        bus.OVR_CLR = 4'b0000;
        chk("ovr_clr", 32'(bus.OVERRUN), 32'h0);
`endif

        // Reset on the 2nd cycle of a 4-cycle pulse, levels held high
        bus.EDGE_MODE = 2'b00;
        bus.PULSE_LEN = 4'd4;
        bus.LVL_SIG   = 4'b1110;
        tick();
        chk("rst_e0", 32'(bus.PULSE_SIG), 32'h0);
        tick();
        chk("rst_e1", 32'(bus.PULSE_SIG), 32'h0);
        tick();
        chk("rst_e2", 32'(bus.PULSE_SIG), 32'h2);
        RST = 1'b1;
        tick();
        chk("rst_mid_p", 32'(bus.PULSE_SIG), 32'h0);
        chk("rst_mid_b", 32'(bus.BUSY), 32'h0);
        tick();
        chk("rst_hold", 32'(bus.PULSE_SIG), 32'h0);
        RST = 1'b0;
        expect_pulse("rst_rel", 4'b1110, 2, 4, 10, -1, 4'b0, 4'd0);

        // All channels rise together
        bus.PULSE_LEN = 4'd3;
        bus.LVL_SIG   = 4'b0000;
        expect_pulse("all_pre", 4'b0000, 0, 0, 6, -1, 4'b0, 4'd0);
        bus.LVL_SIG   = 4'b1111;
        expect_pulse("all", 4'b1111, 2, 3, 8, -1, 4'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
- Multi-channel, parameterised level-to-pulse converter. Successor to the single-channel rising-edge pulse generator.
- Each channel has:
  - a configurable-depth synchroniser;
  - selectable edge detection: rise, fall, both or off;
  - a programmable pulse width in clock cycles.
- Sits on the destination side of clock-domain crossings. Converts enable/toggle levels into single- or multi-cycle strobes for register-file, UART and ALU control logic.

Parameters:
- CH_NUM, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel. Legal range is 1..4.
- PULSE_LEN_W, 4: width of the pulse-length field.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- LVL_SIG  input  CH_NUM  level inputs, one bit per channel. May be asynchronous to CLK.
- EDGE_MODE  input  2  00 rise, 01 fall, 10 both, 11 detection off. Common to all channels.
- PULSE_LEN  input  PULSE_LEN_W  pulse width in cycles. A value of 0 is treated as 1.
- PULSE_SIG  output  CH_NUM  registered output pulses.
- BUSY  output  CH_NUM  pulse in progress. Equal to PULSE_SIG, registered.

Behaviour:
- Reset is synchronous, active-high, sampled on the CLK rising edge. While RST is high at an edge, the following are cleared to 0:
  - sync chains and edge-history flops;
  - down-counters;
  - PULSE_SIG, BUSY, and OVERRUN (if built).
- A level that is already high when RST releases is reported as a rising edge. This follows from the history reset value of 0 and is intended.
- Synchroniser: LVL_SIG[i] → sync[0] → … → sync[S-1], where S = SYNC_STAGES. hist ← sync[S-1] every cycle.
- Edge detection is combinational on sync[S-1] and hist:
  - rise: sync & ~hist
  - fall: ~sync & hist
  - both: sync ^ hist
  - off: 0
- Per-channel FSM, two states:
  - IDLE: on a detected edge, go to ACTIVE at the next edge. Load cnt ← max(PULSE_LEN,1) − 1 and set PULSE_SIG = 1.
  - ACTIVE: if cnt == 0, go to IDLE and set PULSE_SIG = 0. Otherwise cnt ← cnt − 1.
- Latency, worked example. LVL_SIG rises and is first captured at clock edge 0:
  - PULSE_SIG goes high after edge S.
  - It stays high for exactly L = max(PULSE_LEN,1) cycles.
  - It falls after edge S+L.
- Non-retriggerable: an edge detected while the channel is ACTIVE is dropped. This includes the final ACTIVE cycle. The counter is not reloaded.
- Back-to-back edges in IDLE each produce a full pulse.
- EDGE_MODE and PULSE_LEN are sampled only when a pulse is loaded. Changing them mid-pulse does not alter that pulse.
- Setting EDGE_MODE=11 blocks new detections. In-flight pulses complete normally. History keeps tracking the input, so re-enabling never reports a stale edge.
- Maximum pulse length is 2^PULSE_LEN_W − 1 cycles. The counter never wraps.
- Channels are fully independent. Simultaneous edges on all channels all fire in the same cycle.
- RST asserted mid-pulse clears PULSE_SIG at that edge. No pulse is pending after reset.

Optional Feature:
- Macro: MULTI_PULSE_GEN_OVERRUN_EN.
- When defined, two extra ports are added:
  - OVERRUN output CH_NUM: sticky per-channel flag, set when an edge is dropped because the channel is ACTIVE.
  - OVR_CLR input CH_NUM: clears OVERRUN for the corresponding channel.
- If set and clear occur in the same cycle, set wins.
- When not defined, the ports and logic are absent and dropped edges are silent.

Decomposition:
- Shared package holds:
  - EDGE_MODE encodings (EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11);
  - FSM state encodings IDLE/ACTIVE;
  - SYNC_STAGES legal-range constants.
- One sub-module, pulse_gen_ch: contains the sync chain, history, edge detect, FSM and counter for one channel.
- Top level instantiates CH_NUM copies in a generate loop. EDGE_MODE and PULSE_LEN are shared by all copies.

Test Plan:
- Basic rise pulse. S=2, PULSE_LEN=3, EDGE_MODE=00, LVL_SIG[0] 0→1 captured at edge 0 → PULSE_SIG[0] high after edges 2, 3 and 4, low after edge 5. Other channels stay 0.
- Edge modes:
  - EDGE_MODE=01: 1→0 gives one pulse, 0→1 gives none.
  - EDGE_MODE=10: toggling 0→1→0 with 10 cycles between transitions gives two pulses.
  - EDGE_MODE=11: no pulses.
- Length bounds:
  - PULSE_LEN=0 → 1-cycle pulse.
  - PULSE_LEN=15 (W=4) → 15-cycle pulse.
  - Changing PULSE_LEN mid-pulse does not change the pulse width.
- Retrigger:
  - PULSE_LEN=5, second edge arriving 2 cycles into the pulse → a single 5-cycle pulse.
  - With MULTI_PULSE_GEN_OVERRUN_EN defined, OVERRUN[i]=1 until OVR_CLR[i] is pulsed.
- Reset: RST asserted on the 2nd cycle of a 4-cycle pulse → PULSE_SIG=0 at that edge and stays 0. LVL_SIG held high through reset release → one rising pulse S cycles after release.
- Multi-channel: all 4 channels rise in the same cycle → all PULSE_SIG bits are asserted in the same cycle with identical width.
